d_access_unit: RTL and testbench

Data-side access unit of the bfcpu core; sits directly upstream of the data memory port (d_req/d_dir/d_addr/d_wdata/d_ack/d_rdata). Holds the data pointer and turns a decoded data operation from the control unit into zero, one or two memory transactions: pointer move, cell read, cell write, or read-modify-write increment/decrement. Reports completion to the control unit with a one-cycle op_ack pulse.

---
 rtl/d_access_unit_pkg.sv | 24 ++
 rtl/d_access_unit_ptr_counter.sv | 26 ++
 rtl/d_access_unit.sv | 130 +++++++++++++
 tb/tb_d_access_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/d_access_unit_pkg.sv
// Shared encodings for the bfcpu data access path: op codes, bus direction and FSM states.
package d_access_unit_pkg;

  localparam logic [2:0] D_OP_PTR_INC  = 3'd0;
  localparam logic [2:0] D_OP_PTR_DEC  = 3'd1;
  localparam logic [2:0] D_OP_CELL_INC = 3'd2;
  localparam logic [2:0] D_OP_CELL_DEC = 3'd3;
  localparam logic [2:0] D_OP_CELL_RD  = 3'd4;
  localparam logic [2:0] D_OP_CELL_WR  = 3'd5;

  localparam logic DIRECTION_READ  = 1'b0;
  localparam logic DIRECTION_WRITE = 1'b1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_GAP  = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  function automatic logic is_rmw(input logic [2:0] code);
    return (code == D_OP_CELL_INC) || (code == D_OP_CELL_DEC);
  endfunction

endpackage

// File: rtl/d_access_unit_ptr_counter.sv
// Data pointer: up/down counter that wraps within 0..d_mem_length-1.
module d_ptr_counter #(
  parameter int d_addr_width = 8,
  parameter int d_mem_length = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc,
  input  logic                    dec,
  output logic [d_addr_width-1:0] ptr
);

  localparam logic [d_addr_width-1:0] PTR_LAST = d_addr_width'(d_mem_length - 1);
  localparam logic [d_addr_width-1:0] PTR_ONE  = d_addr_width'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + PTR_ONE;
    end else if (dec) begin
      ptr <= (ptr == '0) ? PTR_LAST : ptr - PTR_ONE;
    end
  end

endmodule

// File: rtl/d_access_unit.sv
// Data-side access unit: holds the tape pointer and runs cell read/write/RMW on the data port.
// state | meaning
// IDLE  | waiting for op_req; pointer ops and NOPs finish from here
// RD    | read request on d_*, waiting for d_ack
// GAP   | one cycle with d_req low between the read and write of an RMW
// WR    | write request on d_*, waiting for d_ack
// DONE  | op_ack pulse; op_req is ignored here
module d_access_unit
  import d_access_unit_pkg::*;
#(
  parameter int d_addr_width = 8,
  parameter int d_mem_length = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    op_req,
  input  logic [2:0]              op_code,
  input  logic [7:0]              op_wdata,
  output logic                    op_ack,
  output logic [7:0]              op_rdata,
  output logic                    op_zero,
  output logic [d_addr_width-1:0] d_ptr,
  output logic                    d_req,
  output logic                    d_dir,
  output logic [d_addr_width-1:0] d_addr,
  output logic [7:0]              d_wdata,
  input  logic                    d_ack,
  input  logic [7:0]              d_rdata
);

  logic [2:0] state;
  logic [2:0] op_q;
  logic [7:0] wbuf;
  logic       ptr_inc;
  logic       ptr_dec;

  assign ptr_inc = (state == ST_IDLE) && op_req && (op_code == D_OP_PTR_INC);
  assign ptr_dec = (state == ST_IDLE) && op_req && (op_code == D_OP_PTR_DEC);
  assign op_zero = (op_rdata == 8'd0);

  d_ptr_counter #(
    .d_addr_width(d_addr_width),
    .d_mem_length(d_mem_length)
  ) u_ptr (
    .clk(clk),
    .rst(rst),
    .inc(ptr_inc),
    .dec(ptr_dec),
    .ptr(d_ptr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      wbuf     <= '0;
      d_req    <= 1'b0;
      d_dir    <= DIRECTION_READ;
      d_addr   <= '0;
      d_wdata  <= '0;
      op_ack   <= 1'b0;
      op_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_req) begin
            op_q   <= op_code;
            d_addr <= d_ptr;
            case (op_code)
              D_OP_CELL_RD, D_OP_CELL_INC, D_OP_CELL_DEC: begin
                d_req <= 1'b1;
                state <= ST_RD;
              end
              D_OP_CELL_WR: begin
                wbuf    <= op_wdata;
                d_wdata <= op_wdata;
                d_dir   <= DIRECTION_WRITE;
                d_req   <= 1'b1;
                state   <= ST_WR;
              end
              default: begin
                op_ack <= 1'b1;
                state  <= ST_DONE;
              end
            endcase
          end
        end
        ST_RD: begin
          if (d_ack) begin
            d_req <= 1'b0;
            if (is_rmw(op_q)) begin
              wbuf  <= (op_q == D_OP_CELL_INC) ? d_rdata + 8'd1 : d_rdata - 8'd1;
              state <= ST_GAP;
            end else begin
              op_rdata <= d_rdata;
              op_ack   <= 1'b1;
              state    <= ST_DONE;
            end
          end
        end
        ST_GAP: begin
          // the memory's ready flag needs one cycle with d_req low to clear
          d_req   <= 1'b1;
          d_dir   <= DIRECTION_WRITE;
          d_wdata <= wbuf;
          state   <= ST_WR;
        end
        ST_WR: begin
          if (d_ack) begin
            d_req <= 1'b0;
            d_dir <= DIRECTION_READ;
            if (is_rmw(op_q)) begin
              op_rdata <= wbuf;
            end
            op_ack <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          op_ack <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_d_access_unit.sv
// Scoreboard bench for d_access_unit against a stretchable single-port memory model.
module tb_d_access_unit;
  import d_access_unit_pkg::*;

  logic       clk;
  logic       rst;
  logic       op_req;
  logic [2:0] op_code;
  logic [7:0] op_wdata;
  logic       op_ack;
  logic [7:0] op_rdata;
  logic       op_zero;
  logic [7:0] d_ptr;
  logic       d_req;
  logic       d_dir;
  logic [7:0] d_addr;
  logic [7:0] d_wdata;
  logic       d_ack;
  logic [7:0] d_rdata;

  d_access_unit #(.d_addr_width(8), .d_mem_length(64)) dut (
    .clk(clk), .rst(rst),
    .op_req(op_req), .op_code(op_code), .op_wdata(op_wdata),
    .op_ack(op_ack), .op_rdata(op_rdata), .op_zero(op_zero),
    .d_ptr(d_ptr),
    .d_req(d_req), .d_dir(d_dir), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: writes on any WRITE-direction cycle, acks stretch+1 cycles after d_req rises
  logic [7:0] mem [64];
  int         stretch;
  int         wait_cnt;

  always @(posedge clk) begin
    if (d_dir == DIRECTION_WRITE) mem[d_addr[5:0]] <= d_wdata;
    if (d_req && !d_ack) begin
      if (wait_cnt == stretch) begin
        d_ack    <= 1'b1;
        d_rdata  <= mem[d_addr[5:0]];
        wait_cnt <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      d_ack <= 1'b0;
      if (!d_req) wait_cnt <= 0;
    end
  end

  int n_cmp;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int         lat;
    logic [7:0] rdata;
    logic       zero;
    logic [7:0] ptr;
    int         rises;
  } exp_t;

  exp_t       sb[$];
  int         mptr;
  logic [7:0] last_rd;
  logic [7:0] ref_mem [64];

  // called at the negedge of an IDLE cycle; returns at the negedge of the next IDLE cycle
  task automatic do_op(input logic [2:0] code, input logic [7:0] wdata, input string tag);
    exp_t       e;
    exp_t       g;
    logic [7:0] exp_wdata;
    int         lat;
    int         rises;
    logic       prev_req;
    logic       got;
    exp_wdata = 8'h00;
    e.rises   = 0;
    e.lat     = 1;
    case (code)
      D_OP_PTR_INC: mptr = (mptr + 1) % 64;
      D_OP_PTR_DEC: mptr = (mptr + 63) % 64;
      D_OP_CELL_RD: begin
        last_rd = ref_mem[mptr]; e.lat = 3 + stretch; e.rises = 1;
      end
      D_OP_CELL_WR: begin
        ref_mem[mptr] = wdata; exp_wdata = wdata; e.lat = 3 + stretch; e.rises = 1;
      end
      D_OP_CELL_INC, D_OP_CELL_DEC: begin
        ref_mem[mptr] = (code == D_OP_CELL_INC) ? ref_mem[mptr] + 8'd1 : ref_mem[mptr] - 8'd1;
        last_rd = ref_mem[mptr]; exp_wdata = ref_mem[mptr];
        e.lat = 6 + 2 * stretch; e.rises = 2;
      end
      default: ;
    endcase
    e.rdata = last_rd;
    e.zero  = (last_rd == 8'd0);
    e.ptr   = 8'(mptr);
    sb.push_back(e);

    op_req = 1'b1; op_code = code; op_wdata = wdata;
    lat = 0; rises = 0; prev_req = d_req; got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (d_req && !prev_req) rises++;
      prev_req = d_req;
      if (d_req) begin
        chk({tag, "_addr"}, d_addr, e.ptr);
        chk({tag, "_dir"}, d_dir,
            (code == D_OP_CELL_WR || rises == 2) ? DIRECTION_WRITE : DIRECTION_READ);
        if (d_dir == DIRECTION_WRITE) chk({tag, "_wdata"}, d_wdata, exp_wdata);
      end
      if (e.rises == 2 && lat == 3 + stretch) chk({tag, "_gap_req"}, d_req, 1'b0);
      if (op_ack) got = 1'b1;
    end
    chk({tag, "_ack_seen"}, got, 1'b1);
    g = sb.pop_front();
    chk({tag, "_latency"}, lat, g.lat);
    chk({tag, "_rdata"}, op_rdata, g.rdata);
    chk({tag, "_zero"}, op_zero, g.zero);
    chk({tag, "_ptr"}, d_ptr, g.ptr);
    chk({tag, "_req_count"}, rises, g.rises);
    op_req = 1'b0;
    @(negedge clk);
    chk({tag, "_ack_pulse"}, op_ack, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ack_seen;
    n_cmp = 0; n_err = 0;
    stretch = 0;
    mptr = 0; last_rd = 8'h00;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    rst = 1'b1; op_req = 1'b0; op_code = 3'd0; op_wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_req", d_req, 1'b0);
    chk("rst_dir", d_dir, DIRECTION_READ);
    chk("rst_addr", d_addr, 8'd0);
    chk("rst_wdata", d_wdata, 8'd0);
    chk("rst_ack", op_ack, 1'b0);
    chk("rst_rdata", op_rdata, 8'd0);
    chk("rst_zero", op_zero, 1'b1);
    chk("rst_ptr", d_ptr, 8'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(D_OP_PTR_DEC, 8'h00, "ptr_dec_wrap");
    for (int i = 0; i < 6; i++) do_op(D_OP_PTR_INC, 8'h00, "ptr_inc");
    do_op(D_OP_CELL_WR, 8'h41, "wr41");
    chk("mem5_41", mem[5], 8'h41);
    do_op(D_OP_CELL_RD, 8'h00, "rd41");
    do_op(D_OP_CELL_WR, 8'hFF, "wrff");
    do_op(D_OP_CELL_INC, 8'h00, "inc_ff");
    chk("mem5_inc", mem[5], ref_mem[5]);
    do_op(D_OP_CELL_DEC, 8'h00, "dec_00");
    chk("mem5_dec", mem[5], ref_mem[5]);
    do_op(3'd6, 8'h00, "nop6");
    do_op(3'd7, 8'h00, "nop7");
    for (int i = 0; i < 64; i++) do_op(D_OP_PTR_INC, 8'h00, "ptr_loop");
    chk("ptr_loop_home", d_ptr, 8'd5);

    stretch = 3;
    do_op(D_OP_CELL_RD, 8'h00, "s_rd");
    do_op(D_OP_CELL_INC, 8'h00, "s_inc");
    do_op(D_OP_PTR_INC, 8'h00, "s_ptr");
    do_op(D_OP_CELL_WR, 8'h10, "s_wr");
    do_op(D_OP_CELL_DEC, 8'h00, "s_dec");
    chk("mem6_s", mem[6], ref_mem[6]);
    stretch = 0;

    op_req = 1'b1; op_code = D_OP_CELL_WR; op_wdata = 8'h77;
    @(negedge clk);
    chk("mid_wr_req", d_req, 1'b1);
    chk("mid_wr_dir", d_dir, DIRECTION_WRITE);
    rst = 1'b1;
    #1;
    chk("arst_req", d_req, 1'b0);
    chk("arst_dir", d_dir, DIRECTION_READ);
    chk("arst_ptr", d_ptr, 8'd0);
    chk("arst_ack", op_ack, 1'b0);
    op_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (op_ack) ack_seen++;
    end
    chk("arst_no_ack", ack_seen, 0);
    mptr = 0; last_rd = 8'h00;
    do_op(D_OP_CELL_WR, 8'h5A, "post_wr");
    do_op(D_OP_CELL_RD, 8'h00, "post_rd");
    chk("mem0_5a", mem[0], 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
